// File: rtl/communication_unit.sv
// Handshake controller downstream of instruction fetch: stalls fetch on start/stop/end
// markers, waits on dependency flags, drains and broadcasts a stop mask, halts on end.
module communication_unit #(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        communication_enable_in,
    input  logic [18:0] communication_signal_in,
    input  logic [15:0] dependency_flags_in,
    input  logic        signal_ack_in,
    output logic        wait_for_next_out,
    output logic [15:0] signal_out,
    output logic        signal_valid_out,
    output logic        execution_done_out,
    output logic        protocol_error_out
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DEP,
        DRAIN,
        SIGNAL,
        HALT
    } state_t;

    localparam logic [1:0] OP_END      = 2'b00;
    localparam logic [1:0] OP_RESERVED = 2'b01;
    localparam logic [1:0] OP_START    = 2'b10;
    localparam logic [1:0] OP_STOP     = 2'b11;

    state_t      state_q, state_d;
    logic [15:0] dep_mask_q, dep_mask_d;
    logic [15:0] sig_mask_q, sig_mask_d;
    logic [3:0]  drain_cnt_q, drain_cnt_d;
    logic        protocol_error_q, protocol_error_d;

    logic [1:0]  opcode;
    logic        dep_flag;
    logic [15:0] marker_mask;

    assign opcode      = communication_signal_in[18:17];
    assign dep_flag    = communication_signal_in[16];
    assign marker_mask = communication_signal_in[15:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            dep_mask_q       <= '0;
            sig_mask_q       <= '0;
            drain_cnt_q      <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            dep_mask_q       <= dep_mask_d;
            sig_mask_q       <= sig_mask_d;
            drain_cnt_q      <= drain_cnt_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        dep_mask_d       = dep_mask_q;
        sig_mask_d       = sig_mask_q;
        drain_cnt_d      = drain_cnt_q;
        protocol_error_d = protocol_error_q;

        case (state_q)
            IDLE: begin
                if (communication_enable_in) begin
                    case (opcode)
                        OP_START: begin
                            if (dep_flag) begin
                                dep_mask_d = marker_mask;
                                state_d    = WAIT_DEP;
                            end
                        end
                        OP_STOP: begin
                            sig_mask_d  = marker_mask;
                            drain_cnt_d = 4'(DRAIN_CYCLES);
                            state_d     = DRAIN;
                        end
                        OP_END:  state_d = HALT;
                        default: protocol_error_d = 1'b1;
                    endcase
                end
            end
            WAIT_DEP: begin
                if ((dependency_flags_in & dep_mask_q) == dep_mask_q) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q - 4'd1;
                if (drain_cnt_q == 4'd1) begin
                    state_d = SIGNAL;
                end
            end
            SIGNAL: begin
                if (signal_ack_in) begin
                    state_d = IDLE;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        // A marker outside IDLE is ignored apart from flagging the error.
        if (communication_enable_in && (state_q != IDLE)) begin
            protocol_error_d = 1'b1;
        end
    end

    always_comb begin
        wait_for_next_out  = (state_q != IDLE) ||
                             (communication_enable_in && (opcode != OP_RESERVED) &&
                              !((opcode == OP_START) && !dep_flag));
        signal_valid_out   = (state_q == SIGNAL);
        signal_out         = (state_q == SIGNAL) ? sig_mask_q : 16'h0000;
        execution_done_out = (state_q == HALT);
        protocol_error_out = protocol_error_q;
    end

endmodule

// File: doc/communication_unit.md
# communication_unit

Inter-process handshake controller sitting directly downstream of the instruction fetch unit. It consumes `communication_enable_out` / `communication_signal_out` (start, stop and end markers) from fetch and drives the fetch unit's `wait_for_next_in` stall. It holds fetch while a dependent process waits for its prerequisite flags, drains the pipeline before broadcasting a stop mask, and halts fetch permanently on end.

## Interface
- `DRAIN_CYCLES`, default 4: cycles the pipeline is allowed to drain after a stop before the signal mask is broadcast; legal range 1..15.

- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `communication_enable_in`  in  1  from fetch `communication_enable_out`; the current instruction is a communication marker.
- `communication_signal_in`  in  19  from fetch: [18:17] opcode (10 start, 11 stop, 00 end, 01 reserved); [16] dependency flag (start only); [15:0] mask.
- `dependency_flags_in`  in  16  completion flags of other processes, level-sensitive.
- `signal_ack_in`  in  1  broadcast consumer accepts `signal_out`.
- `wait_for_next_out`  out  1  to fetch `wait_for_next_in`; 1 stalls fetch.
- `signal_out`  out  16  stop mask being broadcast; 0 when not valid.
- `signal_valid_out`  out  1  `signal_out` is valid.
- `execution_done_out`  out  1  end marker consumed; sticky until reset.
- `protocol_error_out`  out  1  sticky; reserved opcode, or a marker arriving outside IDLE.

## Operation
- States: IDLE, WAIT_DEP, DRAIN, SIGNAL, HALT. Registers: `dep_mask`[15:0], `sig_mask`[15:0], `drain_cnt`[3:0].
- Reset (async, `reset`=0): state IDLE, all registers 0. All outputs are 0: `wait_for_next_out`, `signal_out`, `signal_valid_out`, `execution_done_out` and `protocol_error_out`.
- Transitions out of IDLE occur only when `communication_enable_in`=1:
  - start with [16]=0 → stay in IDLE, no stall.
  - start with [16]=1 → capture `dep_mask`=[15:0], go to WAIT_DEP.
  - stop → capture `sig_mask`=[15:0], set `drain_cnt`=DRAIN_CYCLES, go to DRAIN.
  - end → go to HALT.
  - 01 → set `protocol_error_out`, stay in IDLE.
- WAIT_DEP: when `(dependency_flags_in & dep_mask) == dep_mask`, go to IDLE; otherwise hold. A zero mask is satisfied on the first WAIT_DEP cycle.
- DRAIN: decrement `drain_cnt` each cycle. When `drain_cnt`==1, go to SIGNAL.
- SIGNAL: `signal_valid_out`=1 and `signal_out`=`sig_mask`. When `signal_ack_in`=1 in a SIGNAL cycle, go to IDLE next edge. Valid and mask hold stable until ack.
- HALT: terminal until reset. `execution_done_out`=1.
- `communication_enable_in`=1 while not in IDLE: set `protocol_error_out`. The marker is ignored and the state is unchanged.
- `wait_for_next_out` = (state != IDLE) OR (`communication_enable_in` AND opcode != 01 AND NOT (start AND [16]=0)).
  - This is combinational from the inputs, so fetch stalls in the same cycle the marker is presented.

## Timing
- Independent start: zero stall cycles.
- Dependent start, marker in cycle N:
  - Stall in N.
  - WAIT_DEP from N+1.
  - If flags are satisfied in cycle M≥N+1, state is IDLE at M+1 and `wait_for_next_out`=0 in M+1.
- Stop, marker in cycle N:
  - DRAIN in cycles N+1..N+DRAIN_CYCLES.
  - SIGNAL from N+DRAIN_CYCLES+1.
  - With ack in the first SIGNAL cycle, IDLE at N+DRAIN_CYCLES+2. Total stall is DRAIN_CYCLES+2 cycles.
- End in N: HALT from N+1. `execution_done_out`=1 from N+1; `wait_for_next_out`=1 from N onward.
- Reset mid-operation: outputs clear immediately (asynchronously) and no broadcast occurs. Captured masks are discarded.
- `dependency_flags_in` is sampled every WAIT_DEP cycle. Flags that drop before the mask is complete delay release; there is no latching.

## Test plan
- Reset then independent start (signal 19'b10_0_0…0) → `wait_for_next_out` stays 0; no state change; all other outputs 0.
- Dependent start with mask 16'h21E6 and flags 16'h21E0, then flags 16'h21E6 from cycle N+5:
  - `wait_for_next_out`=1 for cycles N..N+5, 0 at N+6.
  - Repeat with mask 0: released at N+2.
- Stop with mask 16'h00A5, DRAIN_CYCLES=4, ack held 1:
  - `signal_valid_out`=1 only in cycle N+5 with `signal_out`=16'h00A5.
  - Stall is exactly cycles N..N+5.
  - Repeat with ack delayed 3 cycles: valid and mask held for 4 cycles.
- End marker → `execution_done_out`=1 from N+1. A later stop marker leaves the state at HALT and sets `protocol_error_out`.
- Opcode 01 → `protocol_error_out`=1 sticky, no stall. Asserting `reset`=0 mid-DRAIN → all outputs 0 immediately; IDLE after release.
- Full program sequence: start(indep), stop(5'h…), start(dep 16'h21E6), stop, end → stall profile matches the Timing section cycle by cycle.
